game_step_sched: RTL and testbench

//  Per-frame scheduler for the TankWar game-logic engine. On each selected

---
 rtl/game_step_if.sv | 21 ++
 rtl/game_step_sched.sv | 195 +++++++++++++++++++
 tb/tb_game_step_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_step_if.sv
// Step handshake between the frame scheduler and the object-update engine.
// The scheduler presents one update step at a time; the engine accepts it with step_ready.
interface game_step_if #(
  parameter int IDX_W = 4
);
  logic             step_valid;
  logic [1:0]       step_kind;
  logic [IDX_W-1:0] step_idx;
  logic [1:0]       step_dir;
  logic             step_ready;

  modport master (
    output step_valid, step_kind, step_idx, step_dir,
    input  step_ready
  );

  modport slave (
    input  step_valid, step_kind, step_idx, step_dir,
    output step_ready
  );
endinterface

// File: rtl/game_step_sched.sv
// TankWar per-frame step scheduler.
// On each selected vblank this block issues the ordered update sequence:
// tank moves, an optional bullet spawn, bullet advances, then one collision scan.
// It also debounces the shoot button, enforces the shot cooldown and flags overrun.
module game_step_sched #(
  parameter int N_TANKS        = 4,
  parameter int N_BULLETS      = 8,
  parameter int TICK_DIV       = 2,
  parameter int SHOOT_COOLDOWN = 16,
  parameter int IDX_W          = 4
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              frame_start,
  input  logic [1:0]        player_dir,
  input  logic              player_move,
  input  logic              shoot_req,
  game_step_if.master       step,
  output logic              busy,
  output logic              tick_done,
  output logic              overrun
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CD_W  = $clog2(SHOOT_COOLDOWN + 1);

  localparam logic [IDX_W-1:0] LAST_TANK   = IDX_W'(N_TANKS - 1);
  localparam logic [IDX_W-1:0] LAST_BULLET = IDX_W'(N_BULLETS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
  localparam logic [CD_W-1:0]  CD_LOAD     = CD_W'(SHOOT_COOLDOWN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TANKS,
    S_SPAWN,
    S_BULLETS,
    S_COLLIDE,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] cnt, cnt_n;
  logic             valid_q, valid_n;

  // Frame snapshot: the player direction and whether this sequence spawns a bullet.
  logic [1:0]       snap_dir;
  logic             snap_spawn;

  logic [DIV_W-1:0] div_cnt;
  logic [CD_W-1:0]  cooldown;
  logic             pending;
  logic             shoot_prev;
  logic             overrun_q;

  logic start, spawn_xfer, shoot_edge, cd_zero, spawn_ok_now;

  assign cd_zero      = (cooldown == '0);
  assign spawn_ok_now = pending && cd_zero;
  assign shoot_edge   = shoot_req && !shoot_prev;
  assign start        = frame_start && (state == S_IDLE) && (div_cnt == DIV_LAST);
  assign spawn_xfer   = valid_q && step.step_ready && (state == S_SPAWN);

  // State register: sequence position, registered step_valid and the frame snapshot.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state      <= S_IDLE;
      cnt        <= '0;
      valid_q    <= 1'b0;
      snap_dir   <= 2'b00;
      snap_spawn <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state   <= state_n;
      cnt     <= cnt_n;
      valid_q <= valid_n;
      if (start) begin
        snap_dir   <= player_dir;
        snap_spawn <= spawn_ok_now;
      end
    end
  end

  // Next-state logic: the current (state, cnt) names the step being presented; advance on transfer.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    state_n = state;
    cnt_n   = cnt;
    valid_n = valid_q;
    case (state)
      S_IDLE: begin
        valid_n = 1'b0;
        if (start) begin
          if (player_move || (N_TANKS > 1)) begin
            // With no move held, tank 0 is skipped and the first step is tank 1.
            state_n = S_TANKS;
            cnt_n   = player_move ? '0 : IDX_W'(1);
          end else begin
            state_n = spawn_ok_now ? S_SPAWN : S_BULLETS;
            cnt_n   = '0;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        valid_n = 1'b0;
      end
      default: begin
        if (!valid_q) begin
          // First cycle after start: the opening step becomes visible next cycle.
          valid_n = 1'b1;
        end else if (step.step_ready) begin
          cnt_n = cnt + 1'b1;
          case (state)
            S_TANKS: begin
              if (cnt == LAST_TANK) begin
                cnt_n   = '0;
                state_n = snap_spawn ? S_SPAWN : S_BULLETS;
              end
            end
            S_SPAWN: begin
              cnt_n   = '0;
              state_n = S_BULLETS;
            end
            S_BULLETS: begin
              if (cnt == LAST_BULLET) begin
                cnt_n   = '0;
                state_n = S_COLLIDE;
              end
            end
            default: begin
              cnt_n   = '0;
              state_n = S_DONE;
              valid_n = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  // Output decode: step fields follow the state, so they hold steady while a step waits.
  always_comb begin
    step.step_kind = 2'b00;
    step.step_idx  = '0;
    step.step_dir  = 2'b00;
    tick_done      = 1'b0;
    case (state)
      S_TANKS: begin
        step.step_kind = 2'b00;
        step.step_idx  = cnt;
        if (cnt == '0) step.step_dir = snap_dir;
      end
      S_SPAWN: begin
        step.step_kind = 2'b10;
        step.step_dir  = snap_dir;
      end
      S_BULLETS: begin
        step.step_kind = 2'b01;
        step.step_idx  = cnt;
      end
      S_COLLIDE: step.step_kind = 2'b11;
      S_DONE:    tick_done = 1'b1;
      default:   ;
    endcase
  end

  assign step.step_valid = valid_q;
  assign busy            = (state != S_IDLE);
  assign overrun         = overrun_q;

  // Frame divider, shoot debounce/cooldown and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      div_cnt    <= '0;
      cooldown   <= '0;
      pending    <= 1'b0;
      shoot_prev <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      shoot_prev <= shoot_req;
      if (frame_start) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (frame_start && (state != S_IDLE)) overrun_q <= 1'b1;
      if (spawn_xfer) begin
        // A spawn consumes the pending shot and restarts the cooldown, even over a same-cycle edge.
        pending  <= 1'b0;
        cooldown <= CD_LOAD;
      end else begin
        if (shoot_edge && cd_zero) pending <= 1'b1;
        if (frame_start && !cd_zero) cooldown <= cooldown - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_game_step_sched.sv
// Bench for game_step_sched: a queue-based reference model predicts every output each cycle,
// directed scenarios pin the model with hand-derived values, then a randomized run follows.
`timescale 1ns/1ps
module tb_game_step_sched;

  localparam int NT = 4;
  localparam int NB = 8;
  localparam int TD = 2;
  localparam int CD = 16;
  localparam int IW = 4;

  typedef struct {
    logic [1:0] kind;
    int         idx;
    logic [1:0] dir;
  } step_t;

  logic       clk;
  logic       rstn;
  logic       frame_start;
  logic [1:0] player_dir;
  logic       player_move;
  logic       shoot_req;
  logic       busy, tick_done, overrun;

  game_step_if #(.IDX_W(IW)) sif ();

  game_step_sched #(
    .N_TANKS(NT), .N_BULLETS(NB), .TICK_DIV(TD), .SHOOT_COOLDOWN(CD), .IDX_W(IW)
  ) dut (
    .clk         (clk),
    .RSTN        (rstn),
    .frame_start (frame_start),
    .player_dir  (player_dir),
    .player_move (player_move),
    .shoot_req   (shoot_req),
    .step        (sif),
    .busy        (busy),
    .tick_done   (tick_done),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit    m_busy, m_setup, m_done, m_overrun, m_pending, m_prev;
  int    m_div, m_cd;
  step_t m_q[$];
  bit    m_xfer, m_spawn_x, m_edge, m_busy_old, m_ev;
  int    m_div_old, m_cd_old;
  bit    m_pend_old;

  // Transfer log taken from the DUT pins, used by the hand-computed checks.
  int         xfer_cnt = 0, spawn_cnt = 0, done_cnt = 0, valid_cyc = 0;
  logic [1:0] log_kind [4096];
  int         log_idx  [4096];
  logic [1:0] log_dir  [4096];

  function automatic void build_seq(input bit mv, input logic [1:0] d, input bit sp);
    m_q.delete();
    for (int t = 0; t < NT; t++) begin
      if (t == 0 && !mv) continue;
      m_q.push_back('{2'd0, t, (t == 0) ? d : 2'd0});
    end
    if (sp) m_q.push_back('{2'd2, 0, d});
    for (int b = 0; b < NB; b++) m_q.push_back('{2'd1, b, 2'd0});
    m_q.push_back('{2'd3, 0, 2'd0});
  endfunction

  always @(posedge clk) begin
    if (rstn && sif.step_valid && sif.step_ready) begin
      log_kind[xfer_cnt & 4095] = sif.step_kind;
      log_idx [xfer_cnt & 4095] = int'(sif.step_idx);
      log_dir [xfer_cnt & 4095] = sif.step_dir;
      xfer_cnt++;
      if (sif.step_kind == 2'd2) spawn_cnt++;
    end
    if (rstn && tick_done) done_cnt++;
    if (rstn && sif.step_valid) valid_cyc++;

    if (!rstn) begin
      m_busy = 0; m_setup = 0; m_done = 0; m_overrun = 0;
      m_pending = 0; m_prev = 1; m_div = 0; m_cd = 0;
      m_q.delete();
    end else begin
      m_busy_old = m_busy;
      m_div_old  = m_div;
      m_cd_old   = m_cd;
      m_pend_old = m_pending;
      m_xfer     = m_busy && !m_setup && !m_done && sif.step_ready;
      m_spawn_x  = m_xfer && (m_q[0].kind == 2'd2);
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (m_busy && m_setup) begin
        m_setup = 0;
      end else if (m_xfer) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1;
      end
      if (frame_start) begin
        if (m_busy_old) m_overrun = 1;
        else if (m_div_old == TD - 1) begin
          build_seq(player_move, player_dir, m_pend_old && (m_cd_old == 0));
          m_busy  = 1;
          m_setup = 1;
        end
        m_div = (m_div_old == TD - 1) ? 0 : m_div_old + 1;
      end
      m_edge = shoot_req && !m_prev;
      if (m_spawn_x) begin
        m_pending = 0;
        m_cd      = CD;
      end else begin
        if (m_edge && m_cd_old == 0) m_pending = 1;
        if (frame_start && m_cd_old > 0) m_cd = m_cd_old - 1;
      end
      m_prev = shoot_req;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    m_ev = m_busy && !m_setup && !m_done;
    check("step_valid", sif.step_valid, m_ev);
    check("busy", busy, m_busy);
    check("tick_done", tick_done, m_done);
    check("overrun", overrun, m_overrun);
    if (m_ev) begin
      check("step_kind", sif.step_kind, m_q[0].kind);
      check("step_idx", int'(sif.step_idx), m_q[0].idx);
      check("step_dir", sif.step_dir, m_q[0].dir);
    end else if (!m_busy) begin
      check("idle_kind", sif.step_kind, 0);
      check("idle_idx", int'(sif.step_idx), 0);
      check("idle_dir", sif.step_dir, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick_n(1);
    frame_start = 1'b0;
  endtask

  task automatic run_frames(input int n);
    repeat (n) begin
      pulse_frame();
      tick_n(24);
    end
  endtask

  task automatic shoot_edge();
    shoot_req = 1'b0;
    tick_n(1);
    shoot_req = 1'b1;
    tick_n(1);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      tick_n(1);
      i++;
    end
    check("wait_idle", busy, 0);
  endtask

  task automatic start_seq();
    for (int a = 0; a < 4; a++) begin
      pulse_frame();
      if (busy) break;
      tick_n(5);
    end
    check("start_seq", busy, 1);
  endtask

  task automatic check_log(input string name, input int k, input int kind, input int idx, input int dir);
    check({name, "_kind"}, log_kind[k & 4095], kind);
    check({name, "_idx"}, log_idx[k & 4095], idx);
    check({name, "_dir"}, log_dir[k & 4095], dir);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int base, sbase, dbase, vbase, hold, gap, since;
  bit found;

  initial begin
    rstn = 1'b0; frame_start = 1'b0; player_dir = 2'b00; player_move = 1'b0;
    shoot_req = 1'b1; sif.step_ready = 1'b0;

    // 1: reset with random inputs, shoot held high through release.
    for (int i = 0; i < 6; i++) begin
      player_dir     = 2'($urandom_range(0, 3));
      player_move    = 1'($urandom_range(0, 1));
      frame_start    = 1'($urandom_range(0, 1));
      sif.step_ready = 1'($urandom_range(0, 1));
      tick_n(1);
    end
    frame_start = 1'b0;
    check("rst_valid", sif.step_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", tick_done, 0);
    check("rst_overrun", overrun, 0);
    rstn = 1'b1;

    // 2: move=0, three frames -> one sequence at the second frame, no spawn.
    player_move = 1'b0; sif.step_ready = 1'b1;
    base = xfer_cnt; sbase = spawn_cnt; dbase = done_cnt;
    pulse_frame();
    check("div_first_idle", busy, 0);
    tick_n(30);
    pulse_frame();
    wait_idle(60);
    pulse_frame();
    tick_n(30);
    check("t2_xfers", xfer_cnt - base, 12);
    check_log("t2_first", base, 0, 1, 0);
    check_log("t2_bullet0", base + 3, 1, 0, 0);
    check_log("t2_last", base + 11, 3, 0, 0);
    check("t2_done", done_cnt - dbase, 1);
    check("t2_spawn", spawn_cnt - sbase, 0);

    // 3: move=1 dir=10 with a shoot edge -> spawn; cooldown blocks an early second shot.
    player_move = 1'b1; player_dir = 2'b10;
    shoot_edge();
    base = xfer_cnt; sbase = spawn_cnt;
    pulse_frame();
    check("lat_cycle1", sif.step_valid, 0);
    tick_n(1);
    check("lat_cycle2", sif.step_valid, 1);
    wait_idle(60);
    check("t3_xfers", xfer_cnt - base, 14);
    check_log("t3_tank0", base, 0, 0, 2);
    check_log("t3_tank1", base + 1, 0, 1, 0);
    check_log("t3_spawn", base + 4, 2, 0, 2);
    check_log("t3_bullet0", base + 5, 1, 0, 0);
    check_log("t3_collide", base + 13, 3, 0, 0);
    check("t3_spawn_cnt", spawn_cnt - sbase, 1);
    sbase = spawn_cnt;
    run_frames(5);
    shoot_edge();
    run_frames(2);
    check("t3_cooldown_drop", spawn_cnt - sbase, 0);
    run_frames(12);
    shoot_edge();
    run_frames(2);
    check("t3_after_cooldown", spawn_cnt - sbase, 1);

    // 4: ready pattern 0,0,1 per step -> each step held three cycles.
    sif.step_ready = 1'b0;
    start_seq();
    base = xfer_cnt; vbase = valid_cyc; hold = 0;
    for (int i = 0; i < 200 && !tick_done; i++) begin
      if (sif.step_valid) begin
        sif.step_ready = (hold == 2);
        hold = (hold == 2) ? 0 : hold + 1;
      end else begin
        sif.step_ready = 1'b0;
        hold = 0;
      end
      tick_n(1);
    end
    sif.step_ready = 1'b0;
    check("t4_finished", tick_done, 1);
    check("t4_xfers", xfer_cnt - base, 13);
    check("t4_valid_cycles", valid_cyc - vbase, 39);
    tick_n(2);

    // 5: engine stalls, next frame arrives while busy -> sticky overrun.
    start_seq();
    tick_n(5);
    pulse_frame();
    check("t5_overrun", overrun, 1);
    check("t5_busy", busy, 1);
    tick_n(3);
    sif.step_ready = 1'b1;
    wait_idle(60);
    check("t5_sticky", overrun, 1);
    rstn = 1'b0;
    tick_n(1);
    rstn = 1'b1;
    check("t5_cleared", overrun, 0);

    // 6: reset mid-bullets, then a fresh sequence and a spawn with cooldown cleared.
    shoot_edge();
    start_seq();
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (sif.step_valid && sif.step_kind == 2'd1 && sif.step_idx == 4'd3) begin
        found = 1;
        break;
      end
      tick_n(1);
    end
    check("t6_found_b3", found, 1);
    rstn = 1'b0;
    tick_n(1);
    check("t6_valid", sif.step_valid, 0);
    check("t6_busy", busy, 0);
    rstn = 1'b1;
    base = xfer_cnt; sbase = spawn_cnt;
    shoot_edge();
    start_seq();
    wait_idle(60);
    check_log("t6_first", base, 0, 0, 2);
    check("t6_spawn", spawn_cnt - sbase, 1);

    // Randomized run against the model.
    rstn = 1'b0;
    tick_n(2);
    rstn = 1'b1;
    gap = 20; since = 0;
    for (int c = 0; c < 3000; c++) begin
      frame_start = (since >= gap);
      if (frame_start) begin
        since = 0;
        gap = $urandom_range(12, 40);
      end else begin
        since++;
      end
      sif.step_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) shoot_req = ~shoot_req;
      if ($urandom_range(0, 15) == 0) player_move = 1'($urandom_range(0, 1));
      player_dir = 2'($urandom_range(0, 3));
      rstn = ($urandom_range(0, 999) != 0);
      tick_n(1);
    end
    frame_start = 1'b0; rstn = 1'b1; sif.step_ready = 1'b1;
    wait_idle(100);
    tick_n(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
